// File: rtl/exc_collect.sv
// exc_collect: precise-exception collection pipe sitting just upstream of CP0.
// Tracks exception/eret state for the instructions in EX, MEM and WB, samples
// the interrupt-pending condition and presents one committed report at WB.
module exc_collect #(
  parameter logic [4:0] CODE_INT    = 5'h00,
  parameter logic [4:0] CODE_HLT    = 5'h01,
  parameter logic [4:0] CODE_RESUME = 5'h02,
  parameter logic [4:0] CODE_ADEL   = 5'h04,
  parameter logic [4:0] CODE_ADES   = 5'h05,
  parameter logic [4:0] CODE_SYS    = 5'h08,
  parameter logic [4:0] CODE_BP     = 5'h09,
  parameter logic [4:0] CODE_RI     = 5'h0a,
  parameter logic [4:0] CODE_OF     = 5'h0c
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_stall,
  input  logic        i_flush,
  input  logic        i_id_valid,
  input  logic [31:0] i_id_pc,
  input  logic        i_id_bd,
  input  logic        i_id_eret,
  input  logic        i_if_adel,
  input  logic        i_id_ri,
  input  logic        i_id_sys,
  input  logic        i_id_bp,
  input  logic        i_id_hlt,
  input  logic        i_id_resume,
  input  logic        i_ex_of,
  input  logic        i_mem_adel,
  input  logic        i_mem_ades,
  input  logic        i_ie,
  input  logic        i_exl,
  input  logic [7:0]  i_int_mask,
  input  logic [7:0]  i_int_sig,
  output logic        o_ex_wb,
  output logic [4:0]  o_ex_code,
  output logic [31:0] o_epc,
  output logic        o_branch_delay_wb,
  output logic        o_eret_flush,
  output logic        o_int_pending
);

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic        bd;
    logic        eret;
    logic        exc;
    logic [4:0]  code;
  } stage_t;

  stage_t r_e, r_m, r_w;
  stage_t w_e_nxt, w_m_nxt, w_w_nxt;
  logic   r_int_pending;
  logic   w_int_req;
  logic   w_take_int;

  // ID flag resolution: the earliest-detected cause in program order wins.
  always_comb begin
    w_e_nxt       = '0;
    w_e_nxt.valid = i_id_valid;
    w_e_nxt.pc    = i_id_pc;
    w_e_nxt.bd    = i_id_bd;
    w_e_nxt.eret  = i_id_eret;
    w_e_nxt.exc   = i_if_adel | i_id_ri | i_id_sys | i_id_bp | i_id_hlt | i_id_resume;
    if (i_if_adel)        w_e_nxt.code = CODE_ADEL;
    else if (i_id_ri)     w_e_nxt.code = CODE_RI;
    else if (i_id_sys)    w_e_nxt.code = CODE_SYS;
    else if (i_id_bp)     w_e_nxt.code = CODE_BP;
    else if (i_id_hlt)    w_e_nxt.code = CODE_HLT;
    else if (i_id_resume) w_e_nxt.code = CODE_RESUME;
    else                  w_e_nxt.code = 5'h00;
  end

  // EX overflow is only recorded when no earlier exception is already carried.
  always_comb begin
    w_m_nxt = r_e;
    if (r_e.valid && !r_e.exc && i_ex_of) begin
      w_m_nxt.exc  = 1'b1;
      w_m_nxt.code = CODE_OF;
    end
  end

  // MEM address errors, load before store, again never overwriting an earlier cause.
  always_comb begin
    w_w_nxt = r_m;
    if (r_m.valid && !r_m.exc) begin
      if (i_mem_adel) begin
        w_w_nxt.exc  = 1'b1;
        w_w_nxt.code = CODE_ADEL;
      end else if (i_mem_ades) begin
        w_w_nxt.exc  = 1'b1;
        w_w_nxt.code = CODE_ADES;
      end
    end
  end

  // Stage registers: reset clears everything, flush kills valids, stall holds.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_e <= '0;
      r_m <= '0;
      r_w <= '0;
    end else if (i_flush) begin
      r_e.valid <= 1'b0;
      r_m.valid <= 1'b0;
      r_w.valid <= 1'b0;
    end else if (!i_stall) begin
      r_e <= w_e_nxt;
      r_m <= w_m_nxt;
      r_w <= w_w_nxt;
    end
  end

  assign w_int_req = i_ie & ~i_exl & (|(i_int_sig & i_int_mask));

  // Interrupt sampling keeps running under stall so a held WB instruction
  // still sees a fresh pending state; flush drops it for one edge.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) r_int_pending <= 1'b0;
    else                  r_int_pending <= w_int_req;
  end

  assign w_take_int        = r_w.valid & r_int_pending;
  assign o_ex_wb           = ~i_stall & r_w.valid & (r_w.exc | r_int_pending);
  assign o_ex_code         = !r_w.valid ? 5'h00 : (w_take_int ? CODE_INT : r_w.code);
  assign o_epc             = r_w.pc;
  assign o_branch_delay_wb = r_w.bd;
  assign o_eret_flush      = ~i_stall & r_w.valid & r_w.eret & ~o_ex_wb;
  assign o_int_pending     = r_int_pending;

endmodule

// File: tb/tb_exc_collect.sv
// Directed bench for exc_collect: one task per scenario, inline checks.
module tb_exc_collect;
  logic        clk = 1'b0;
  logic        rst, stall, flush;
  logic        id_valid, id_bd, id_eret;
  logic [31:0] id_pc;
  logic        if_adel, id_ri, id_sys, id_bp, id_hlt, id_resume;
  logic        ex_of, mem_adel, mem_ades;
  logic        ie, exl;
  logic [7:0]  int_mask, int_sig;
  logic        ex_wb, bd_wb, eret_flush, int_pending;
  logic [4:0]  ex_code;
  logic [31:0] epc;
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  exc_collect dut (
    .i_clk(clk), .i_rst(rst), .i_stall(stall), .i_flush(flush),
    .i_id_valid(id_valid), .i_id_pc(id_pc), .i_id_bd(id_bd), .i_id_eret(id_eret),
    .i_if_adel(if_adel), .i_id_ri(id_ri), .i_id_sys(id_sys), .i_id_bp(id_bp),
    .i_id_hlt(id_hlt), .i_id_resume(id_resume),
    .i_ex_of(ex_of), .i_mem_adel(mem_adel), .i_mem_ades(mem_ades),
    .i_ie(ie), .i_exl(exl), .i_int_mask(int_mask), .i_int_sig(int_sig),
    .o_ex_wb(ex_wb), .o_ex_code(ex_code), .o_epc(epc),
    .o_branch_delay_wb(bd_wb), .o_eret_flush(eret_flush), .o_int_pending(int_pending)
  );

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_id();
    id_valid = 0; id_pc = '0; id_bd = 0; id_eret = 0;
    {if_adel, id_ri, id_sys, id_bp, id_hlt, id_resume} = 6'b0;
  endtask

  // flags = {if_adel, ri, sys, bp, hlt, resume}
  task automatic drive_id(input logic [31:0] pc, input logic bd, input logic er,
                          input logic [5:0] flags);
    id_valid = 1; id_pc = pc; id_bd = bd; id_eret = er;
    {if_adel, id_ri, id_sys, id_bp, id_hlt, id_resume} = flags;
  endtask

  // Push one instruction to WB; leaves sampling point 1 time unit after inputs settle.
  task automatic run_one(input logic [31:0] pc, input logic bd, input logic er,
                         input logic [5:0] flags, input logic of,
                         input logic adel, input logic ades);
    drive_id(pc, bd, er, flags);
    step();
    clear_id();
    ex_of = of;
    step();
    ex_of = 0;
    mem_adel = adel; mem_ades = ades;
    step();
    mem_adel = 0; mem_ades = 0;
    #1;
  endtask

  task automatic clear_w();
    flush = 1;
    step();
    flush = 0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1; stall = 0; flush = 0; clear_id();
    ex_of = 0; mem_adel = 0; mem_ades = 0;
    ie = 0; exl = 0; int_mask = 0; int_sig = 0;
    step(); step();
    rst = 0;
    #1;
    n_cmp++; if (ex_wb !== 1'b0) begin n_err++; $display("FAIL reset_ex_wb: got %b want 0", ex_wb); end
    n_cmp++; if (ex_code !== 5'h00) begin n_err++; $display("FAIL reset_code: got %h want 00", ex_code); end
    n_cmp++; if (epc !== 32'h0) begin n_err++; $display("FAIL reset_epc: got %h want 0", epc); end
    n_cmp++; if ({bd_wb, eret_flush, int_pending} !== 3'b000) begin n_err++;
      $display("FAIL reset_flags: got %b want 000", {bd_wb, eret_flush, int_pending}); end
  endtask

  task automatic test_syscall_latency();
    drive_id(32'h0040_0100, 0, 0, 6'b001000);
    step(); clear_id(); #1;
    n_cmp++; if (ex_wb !== 1'b0) begin n_err++; $display("FAIL sys_lat1: got %b want 0", ex_wb); end
    step(); #1;
    n_cmp++; if (ex_wb !== 1'b0) begin n_err++; $display("FAIL sys_lat2: got %b want 0", ex_wb); end
    step(); #1;
    n_cmp++; if (ex_wb !== 1'b1) begin n_err++; $display("FAIL sys_lat3: got %b want 1", ex_wb); end
    n_cmp++; if (ex_code !== 5'h08) begin n_err++; $display("FAIL sys_code: got %h want 08", ex_code); end
    n_cmp++; if (epc !== 32'h0040_0100) begin n_err++; $display("FAIL sys_epc: got %h want 00400100", epc); end
    n_cmp++; if (bd_wb !== 1'b0) begin n_err++; $display("FAIL sys_bd: got %b want 0", bd_wb); end
    clear_w();
    n_cmp++; if (ex_wb !== 1'b0) begin n_err++; $display("FAIL sys_once: got %b want 0", ex_wb); end
  endtask

  task automatic test_priority();
    logic [5:0] flg [9] = '{6'b111111, 6'b011000, 6'b001100, 6'b000110, 6'b000011,
                            6'b000001, 6'b000000, 6'b000000, 6'b000000};
    logic       of  [9] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic       ad  [9] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic       as  [9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [4:0] exp [9] = '{5'h04, 5'h0a, 5'h08, 5'h09, 5'h01, 5'h02, 5'h0c, 5'h04, 5'h05};
    for (int i = 0; i < 9; i++) begin
      run_one(32'h0040_1000 + 32'(i * 4), 0, 0, flg[i], of[i], ad[i], as[i]);
      n_cmp++; if (ex_wb !== 1'b1 || ex_code !== exp[i]) begin n_err++;
        $display("FAIL prio_%0d: got wb=%b code=%h want wb=1 code=%h", i, ex_wb, ex_code, exp[i]); end
      clear_w();
    end
  endtask

  task automatic test_interrupt();
    ie = 1; exl = 0; int_mask = 8'hFF; int_sig = 8'h04;
    #1;
    n_cmp++; if (int_pending !== 1'b0) begin n_err++; $display("FAIL int_lat0: got %b want 0", int_pending); end
    step(); #1;
    n_cmp++; if (int_pending !== 1'b1 || ex_wb !== 1'b0) begin n_err++;
      $display("FAIL int_lat1: got pend=%b wb=%b want pend=1 wb=0", int_pending, ex_wb); end
    run_one(32'h0040_0300, 0, 0, 6'b0, 1, 0, 0);
    n_cmp++; if (ex_wb !== 1'b1 || ex_code !== 5'h00) begin n_err++;
      $display("FAIL int_override: got wb=%b code=%h want wb=1 code=00", ex_wb, ex_code); end
    clear_w();
    exl = 1;
    run_one(32'h0040_0304, 0, 0, 6'b0, 1, 0, 0);
    n_cmp++; if (ex_wb !== 1'b1 || ex_code !== 5'h0c || int_pending !== 1'b0) begin n_err++;
      $display("FAIL int_exl: got wb=%b code=%h pend=%b want 1 0c 0", ex_wb, ex_code, int_pending); end
    clear_w();
    exl = 0; int_mask = 8'h04; int_sig = 8'h08;
    run_one(32'h0040_0308, 0, 0, 6'b0, 0, 0, 0);
    n_cmp++; if (ex_wb !== 1'b0 || int_pending !== 1'b0) begin n_err++;
      $display("FAIL int_masked: got wb=%b pend=%b want 0 0", ex_wb, int_pending); end
    clear_w();
    ie = 0; int_mask = 0; int_sig = 0;
    step();
  endtask

  task automatic test_eret();
    run_one(32'h0040_0200, 0, 1, 6'b0, 0, 0, 0);
    n_cmp++; if (eret_flush !== 1'b1 || ex_wb !== 1'b0 || epc !== 32'h0040_0200) begin n_err++;
      $display("FAIL eret_commit: got ef=%b wb=%b epc=%h want 1 0 00400200", eret_flush, ex_wb, epc); end
    clear_w();
    n_cmp++; if (eret_flush !== 1'b0) begin n_err++; $display("FAIL eret_once: got %b want 0", eret_flush); end
    run_one(32'h0040_0200, 0, 1, 6'b000100, 0, 0, 0);
    n_cmp++; if (ex_wb !== 1'b1 || ex_code !== 5'h09 || eret_flush !== 1'b0) begin n_err++;
      $display("FAIL eret_vs_bp: got wb=%b code=%h ef=%b want 1 09 0", ex_wb, ex_code, eret_flush); end
    clear_w();
  endtask

  task automatic test_stall();
    drive_id(32'h0040_0400, 0, 0, 6'b001000); step();
    drive_id(32'h0040_0404, 1, 0, 6'b000100); step();
    drive_id(32'h0040_0408, 0, 0, 6'b010000); step();
    // W=A(sys), M=B(bp,bd), E=C(ri); perturb inputs that must be ignored while stalled.
    stall = 1;
    drive_id(32'h0bad_0000, 1, 1, 6'b000010);
    ex_of = 1; mem_adel = 1;
    #1;
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (ex_wb !== 1'b0 || epc !== 32'h0040_0400) begin n_err++;
        $display("FAIL stall_hold_%0d: got wb=%b epc=%h want 0 00400400", i, ex_wb, epc); end
      step(); #1;
    end
    clear_id(); ex_of = 0; mem_adel = 0;
    stall = 0; #1;
    n_cmp++; if (ex_wb !== 1'b1 || ex_code !== 5'h08 || epc !== 32'h0040_0400) begin n_err++;
      $display("FAIL stall_release: got wb=%b code=%h epc=%h want 1 08 00400400", ex_wb, ex_code, epc); end
    step(); #1;
    n_cmp++; if (ex_code !== 5'h09 || epc !== 32'h0040_0404 || bd_wb !== 1'b1) begin n_err++;
      $display("FAIL stall_m_kept: got code=%h epc=%h bd=%b want 09 00400404 1", ex_code, epc, bd_wb); end
    step(); #1;
    n_cmp++; if (ex_code !== 5'h0a || epc !== 32'h0040_0408 || bd_wb !== 1'b0) begin n_err++;
      $display("FAIL stall_e_kept: got code=%h epc=%h bd=%b want 0a 00400408 0", ex_code, epc, bd_wb); end
    // flush beats stall
    stall = 1; flush = 1; step(); stall = 0; flush = 0; #1;
    n_cmp++; if (ex_wb !== 1'b0 || ex_code !== 5'h00) begin n_err++;
      $display("FAIL flush_over_stall: got wb=%b code=%h want 0 00", ex_wb, ex_code); end
  endtask

  task automatic test_reset_midstream();
    ie = 1; exl = 0; int_mask = 8'hFF; int_sig = 8'h01;
    drive_id(32'h0040_0500, 1, 0, 6'b001000); step();
    drive_id(32'h0040_0504, 0, 1, 6'b0); step();
    drive_id(32'h0040_0508, 0, 0, 6'b000100); step();
    clear_id();
    rst = 1; step(); #1;
    n_cmp++; if ({ex_wb, eret_flush, bd_wb, int_pending} !== 4'b0000 || ex_code !== 5'h00 || epc !== 32'h0) begin
      n_err++; $display("FAIL rst_mid: got wb=%b ef=%b bd=%b pend=%b code=%h epc=%h want all 0",
                        ex_wb, eret_flush, bd_wb, int_pending, ex_code, epc); end
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      step(); #1;
      n_cmp++; if (ex_wb !== 1'b0 || eret_flush !== 1'b0) begin n_err++;
        $display("FAIL rst_quiet_%0d: got wb=%b ef=%b want 0 0", i, ex_wb, eret_flush); end
    end
    ie = 0;
    run_one(32'h0040_0600, 0, 0, 6'b001000, 0, 0, 0);
    n_cmp++; if (ex_wb !== 1'b1 || ex_code !== 5'h08 || epc !== 32'h0040_0600) begin n_err++;
      $display("FAIL rst_new: got wb=%b code=%h epc=%h want 1 08 00400600", ex_wb, ex_code, epc); end
    clear_w();
  endtask

  initial begin
    test_reset();
    test_syscall_latency();
    test_priority();
    test_interrupt();
    test_eret();
    test_stall();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/exc_collect.md
Name: exc_collect

Overview:
- Precise-exception collection pipe that sits directly upstream of the CP0 register block.
- Carries per-instruction exception and eret information alongside the EX, MEM and WB pipeline stages.
- Samples the interrupt-pending condition from the CP0 STATUS/CAUSE outputs.
- Produces the single committed exception report at WB: ex_wb, ex_code, epc, branch_delay_wb and eret_flush, which drive the CP0 inputs of the same names.

Parameters:
- CODE_INT, 5'h00, interrupt exception code
- CODE_HLT, 5'h01, halt request code
- CODE_RESUME, 5'h02, resume request code
- CODE_ADEL, 5'h04, load/fetch address error code
- CODE_ADES, 5'h05, store address error code
- CODE_SYS, 5'h08, syscall code
- CODE_BP, 5'h09, breakpoint code
- CODE_RI, 5'h0a, reserved instruction code
- CODE_OF, 5'h0c, arithmetic overflow code

Ports:
- clk  in  1  core clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- stall  in  1  pipeline stall; freezes all stage registers
- flush  in  1  CP0 flush (ex or eret); clears all stage valid bits
- id_valid  in  1  valid instruction leaving ID
- id_pc  in  32  PC of that instruction
- id_bd  in  1  instruction sits in a branch delay slot
- id_eret  in  1  instruction is ERET
- if_adel  in  1  fetch address misaligned
- id_ri  in  1  reserved-instruction flag
- id_sys  in  1  syscall flag
- id_bp  in  1  breakpoint flag
- id_hlt  in  1  halt-request flag
- id_resume  in  1  resume-request flag
- ex_of  in  1  overflow detected in EX (applies to the EX-stage instruction)
- mem_adel  in  1  load address error (applies to the MEM-stage instruction)
- mem_ades  in  1  store address error (applies to the MEM-stage instruction)
- ie  in  1  STATUS.IE from CP0
- exl  in  1  STATUS.EXL from CP0
- int_mask  in  8  STATUS.IM from CP0
- int_sig  in  8  CAUSE.IP from CP0
- ex_wb  out  1  exception committed this cycle
- ex_code  out  5  code of the committed exception
- epc  out  32  PC of the WB instruction, raw; CP0 applies the −4 for delay slots
- branch_delay_wb  out  1  WB instruction is in a delay slot
- eret_flush  out  1  ERET committed this cycle
- int_pending  out  1  registered interrupt-pending flag

Behaviour:
- Stage registers E, M, W, each holding {valid, pc[31:0], bd, eret, exc, code[4:0]}.
- Reset: all valid/exc/eret/bd cleared, pc=0, code=0, int_pending=0. All outputs therefore read 0 in the cycle after the reset edge.
- Priority of the edge events: rst > flush > stall > advance.
  - flush=1: clear the valid bit of E, M and W; other fields are don't-care.
  - stall=1 (and no flush): all three registers hold their values.
- Advance on each edge (no flush, no stall):
  - ID→E: E.valid = id_valid; copy pc, bd and eret.
  - ID flags are resolved by fixed priority: if_adel > id_ri > id_sys > id_bp > id_hlt > id_resume. exc = any flag set; code = the winning flag's code.
  - E→M: if E.exc=0 and ex_of=1 and E.valid=1, set exc=1 and code=CODE_OF; otherwise copy E unchanged.
  - M→W: if M.exc=0 and M.valid=1, apply mem_adel (priority) or mem_ades with CODE_ADEL / CODE_ADES; otherwise copy M.
  - First-raised exception wins: later-stage flags never overwrite an existing exc/code.
- Interrupt sampling:
  - int_pending <= ie & ~exl & |(int_sig & int_mask) every edge, including during stall.
  - Cleared by rst. Also cleared by flush, and held 0 on the edge that clears it.
  - Latency: one cycle from the CP0 inputs to int_pending.
- Outputs (combinational from W and int_pending):
  - take_int = W.valid & int_pending.
  - ex_wb = ~stall & W.valid & (W.exc | int_pending).
  - ex_code = take_int ? CODE_INT : W.code. An interrupt overrides any instruction exception.
  - epc = W.pc; branch_delay_wb = W.bd.
  - eret_flush = ~stall & W.valid & W.eret & ~ex_wb. An exception beats ERET.
  - When W.valid=0: ex_wb=0, eret_flush=0, ex_code=0.
- Single report guarantee: CP0 raises flush in the same cycle as ex_wb/eret_flush, so W is invalidated on the next edge and each event is reported exactly once.
- A report held under stall appears in the first cycle with stall=0.
- rst asserted mid-stream discards all in-flight state on that edge, with no report.

Test Plan:
- id_valid=1, id_pc=0x0040_0100, id_sys=1, no stall → ex_wb=1 exactly 3 cycles later, ex_code=0x08, epc=0x0040_0100, branch_delay_wb=0; with flush fed back, ex_wb=0 on the next cycle.
- ID instruction with id_ri=1 and id_sys=1, which then gets mem_adel=1 in MEM → ex_code=0x0a. RI wins at ID and is not overwritten.
- ie=1, exl=0, int_mask=0xFF, int_sig=0x04, valid W instruction carrying code 0x0c → ex_code=0x00, ex_wb=1. Repeat with exl=1 → ex_code=0x0c.
- ERET at pc 0x0040_0200, no exceptions → eret_flush=1 for one cycle at WB, ex_wb=0. Same with id_bp=1 → ex_wb=1, ex_code=0x09, eret_flush=0.
- Exception reaches W while stall=1 for 4 cycles → ex_wb=0 throughout the stall, 1 in the first unstalled cycle; W, M and E contents unchanged across the stall.
- rst=1 asserted while three valid instructions are in flight → next cycle all outputs 0 and int_pending=0; no ex_wb after rst deasserts until a new instruction traverses 3 stages.
